// File: rtl/adaptive_threshold_stream_pkg.sv
// Shared types and sizing helpers for the adaptive threshold engine and its window sub-module.
package at_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  localparam int CYCLE_W = 24;

  // Ceiling log2 for the supported window range 2..64.
  function automatic int log2_win(input int win);
    int r;
    r = 0;
    for (int i = 0; i < 7; i++) begin
      if ((1 << i) < win) r = i + 1;
    end
    return r;
  endfunction

  function automatic int sum_width(input int pix_w, input int win);
    return pix_w + log2_win(win);
  endfunction

endpackage

// File: rtl/adaptive_threshold_stream_if.sv
// Pixel-in / result-out stream bundle: master is the pixel source and frame-memory sink, slave is the engine.
interface adaptive_threshold_stream_if #(
  parameter int PIX_W = 8,
  parameter int XW    = 8,
  parameter int YW    = 8
) ();

  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] in_pixel;
  logic [XW-1:0]    oX;
  logic [YW-1:0]    oY;
  logic             oValue;
  logic             oValid;

  modport master (
    output in_valid, in_pixel,
    input  in_ready, oX, oY, oValue, oValid
  );

  modport slave (
    input  in_valid, in_pixel,
    output in_ready, oX, oY, oValue, oValid
  );

endinterface

// File: rtl/adaptive_threshold_stream_window_sum.sv
// Trailing horizontal window: WIN-deep shift register plus running sum. The sum output already
// includes the pixel presented this cycle, so the decision can be made in the same cycle.
module window_sum
  import at_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int WIN   = 8
) (
  input  logic                               clock,
  input  logic                               not_reset,
  input  logic                               load,
  input  logic                               shift,
  input  logic [PIX_W-1:0]                   pixel,
  output logic [sum_width(PIX_W, WIN)-1:0]   sum
);

  localparam int LOG = log2_win(WIN);
  localparam int SW  = sum_width(PIX_W, WIN);

  logic [PIX_W-1:0] win_q [WIN];
  logic [PIX_W-1:0] win_d [WIN];
  logic [SW-1:0]    sum_q, sum_d;

  // NOTE: every variable gets its default before the if/else, so no path leaves it unassigned (no latch).
  always_comb begin
    win_d = win_q;
    sum_d = sum_q;
    if (load) begin
      for (int i = 0; i < WIN; i++) win_d[i] = pixel;
      sum_d = {pixel, {LOG{1'b0}}};
    end else if (shift) begin
      sum_d    = sum_q + SW'(pixel) - SW'(win_q[WIN-1]);
      win_d[0] = pixel;
      for (int i = 1; i < WIN; i++) win_d[i] = win_q[i-1];
    end
  end

  // NOTE: the window is a handful of flops that must read as zero after reset, so it is reset like
  // any other register instead of being treated as an uninitialised memory.
  always_ff @(posedge clock or negedge not_reset) begin
    if (!not_reset) begin
      for (int i = 0; i < WIN; i++) win_q[i] <= '0;
      sum_q <= '0;
    end else begin
      win_q <= win_d;
      sum_q <= sum_d;
    end
  end

  assign sum = sum_d;

endmodule

// File: rtl/adaptive_threshold_stream.sv
// Streaming adaptive-threshold engine: binarises raster pixels against a trailing window mean.
// Optional per-frame cycle counter enabled by `define ADAPTIVE_THRESHOLD_CYCLE_COUNT_EN.
module adaptive_threshold_stream
  import at_pkg::*;
#(
  parameter int IMG_W = 160,
  parameter int IMG_H = 120,
  parameter int PIX_W = 8,
  parameter int WIN   = 8,
  parameter int XW    = 8,
  parameter int YW    = 8
) (
  input  logic                       clock,
  input  logic                       not_reset,
  input  logic                       start,
  input  logic [PIX_W-1:0]           offset,
  input  logic                       invert,
  adaptive_threshold_stream_if.slave stream,
  output logic                       busy,
  output logic                       done,
  output logic [CYCLE_W-1:0]         cycle_count
);

  localparam int LOG = log2_win(WIN);
  localparam int SW  = sum_width(PIX_W, WIN);

  state_e           state_q, state_d;
  logic [XW-1:0]    x_q, x_d, ox_q, ox_d;
  logic [YW-1:0]    y_q, y_d, oy_q, oy_d;
  logic [PIX_W-1:0] offset_q, offset_d;
  logic             invert_q, invert_d;
  logic             ovalue_q, ovalue_d;
  logic             ovalid_q, ovalid_d;
  logic             done_q, done_d;

  logic             transfer, row_end, last_pixel, raw;
  logic [SW-1:0]    sum;
  logic [PIX_W-1:0] mean;

  assign transfer   = stream.in_valid && (state_q == RUN);
  assign row_end    = (x_q == XW'(IMG_W - 1));
  assign last_pixel = transfer && row_end && (y_q == YW'(IMG_H - 1));

  window_sum #(.PIX_W(PIX_W), .WIN(WIN)) u_window (
    .clock     (clock),
    .not_reset (not_reset),
    .load      (transfer && (x_q == '0)),
    .shift     (transfer && (x_q != '0)),
    .pixel     (stream.in_pixel),
    .sum       (sum)
  );

  // One extra bit so pixel + offset cannot wrap past the mean.
  assign mean = sum[SW-1:LOG];
  assign raw  = ({1'b0, stream.in_pixel} + {1'b0, offset_q}) > {1'b0, mean};

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    offset_d = offset_q;
    invert_d = invert_q;
    ox_d     = ox_q;
    oy_d     = oy_q;
    ovalue_d = ovalue_q;
    ovalid_d = transfer;
    done_d   = (state_q == DONE);
    if (transfer) begin
      ox_d     = x_q;
      oy_d     = y_q;
      ovalue_d = raw ^ invert_q;
    end
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          x_d      = '0;
          y_d      = '0;
          offset_d = offset;
          invert_d = invert;
        end
      end
      RUN: begin
        if (transfer) begin
          if (row_end) begin
            x_d = '0;
            y_d = last_pixel ? '0 : y_q + YW'(1);
          end else begin
            x_d = x_q + XW'(1);
          end
          if (last_pixel) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge not_reset) begin
    if (!not_reset) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      offset_q <= '0;
      invert_q <= 1'b0;
      ox_q     <= '0;
      oy_q     <= '0;
      ovalue_q <= 1'b0;
      ovalid_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      offset_q <= offset_d;
      invert_q <= invert_d;
      ox_q     <= ox_d;
      oy_q     <= oy_d;
      ovalue_q <= ovalue_d;
      ovalid_q <= ovalid_d;
      done_q   <= done_d;
    end
  end

`ifdef ADAPTIVE_THRESHOLD_CYCLE_COUNT_EN
  logic [CYCLE_W-1:0] cyc_q, cyc_d;

  always_comb begin
    cyc_d = cyc_q;
    if (state_q == IDLE) begin
      if (start) cyc_d = '0;
    end else if (cyc_q != '1) begin
      cyc_d = cyc_q + CYCLE_W'(1);
    end
  end

  always_ff @(posedge clock or negedge not_reset) begin
    if (!not_reset) cyc_q <= '0;
    else            cyc_q <= cyc_d;
  end

  assign cycle_count = cyc_q;
`else
  assign cycle_count = '0;
`endif

  // busy covers DONE too, so it falls in the same cycle done pulses.
  assign busy            = (state_q != IDLE);
  assign done            = done_q;
  assign stream.in_ready = (state_q == RUN);
  assign stream.oX       = ox_q;
  assign stream.oY       = oy_q;
  assign stream.oValue   = ovalue_q;
  assign stream.oValid   = ovalid_q;

endmodule

// File: tb/tb_adaptive_threshold_stream.sv
// Self-checking bench: table of hand-computed frames plus corner sequences, results checked via a scoreboard.
module tb_adaptive_threshold_stream;

  localparam int IMG_W = 4;
  localparam int IMG_H = 2;
  localparam int PIX_W = 8;
  localparam int WIN   = 4;
  localparam int XW    = 8;
  localparam int YW    = 8;
  localparam int NPIX  = IMG_W * IMG_H;
  localparam int NFRM  = 7;

  logic        clock = 1'b0;
  logic        not_reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  offset = '0;
  logic        invert = 1'b0;
  logic        busy, done;
  logic [23:0] cycle_count;

  adaptive_threshold_stream_if #(.PIX_W(PIX_W), .XW(XW), .YW(YW)) bus ();

  adaptive_threshold_stream #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(PIX_W), .WIN(WIN), .XW(XW), .YW(YW)
  ) dut (
    .clock       (clock),
    .not_reset   (not_reset),
    .start       (start),
    .offset      (offset),
    .invert      (invert),
    .stream      (bus.slave),
    .busy        (busy),
    .done        (done),
    .cycle_count (cycle_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int strobes = 0;

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          v;
  } exp_t;

  typedef struct {
    logic [7:0] pix;
    logic [7:0] c;
    logic       inv;
    logic       exp_v;
  } vec_t;

  exp_t       sb[$];
  vec_t       tbl[NFRM*NPIX];
  logic [7:0] cur_px[NPIX];
  logic       cur_ev[NPIX];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard sink: every write strobe must match the oldest pending expectation.
  always @(negedge clock) begin
    if (not_reset && bus.oValid === 1'b1) begin
      strobes++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got x=%0d y=%0d v=%0b, expected none", bus.oX, bus.oY, bus.oValue);
      end else begin
        check("result_xyv", {bus.oX, bus.oY, bus.oValue}, sb.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] exp_cc(input int n);
`ifdef ADAPTIVE_THRESHOLD_CYCLE_COUNT_EN
    return 32'(n);
`else
    return 32'(n - n);
`endif
  endfunction

  // Reference mean over an explicit window; slots before the row start repeat the first pixel of the row.
  function automatic logic model_v(input int idx, input logic [7:0] c, input logic inv);
    int rs, s, j;
    rs = idx - (idx % IMG_W);
    s  = 0;
    for (int k = 0; k < WIN; k++) begin
      j = idx - k;
      s += (j < rs) ? int'(cur_px[rs]) : int'(cur_px[j]);
    end
    return ((int'(cur_px[idx]) + int'(c)) > (s / WIN)) ^ inv;
  endfunction

  task automatic set_frame(input int f, input logic [7:0] c, input logic inv,
                           input logic [63:0] pixels, input logic [7:0] ev);
    for (int k = 0; k < NPIX; k++) begin
      tbl[f*NPIX+k].pix   = pixels[63-8*k -: 8];
      tbl[f*NPIX+k].c     = c;
      tbl[f*NPIX+k].inv   = inv;
      tbl[f*NPIX+k].exp_v = ev[7-k];
    end
  endtask

  task automatic load_frame(input int f);
    for (int k = 0; k < NPIX; k++) begin
      cur_px[k] = tbl[f*NPIX+k].pix;
      cur_ev[k] = tbl[f*NPIX+k].exp_v;
    end
  endtask

  // Runs one whole frame from cur_px/cur_ev; toggle inserts a stall every other cycle,
  // restart_at pulses start while that pixel index is being offered.
  task automatic run_frame(input logic [7:0] c, input logic inv, input bit toggle, input int restart_at);
    int   sent, stalls, cyc, x, y, s0;
    exp_t e;
    sent = 0; stalls = 0; cyc = 0; x = 0; y = 0; s0 = strobes;
    offset = c; invert = inv; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; offset = '0; invert = 1'b0;
    check("busy_after_start", busy, 1);
    while (sent < NPIX && cyc < 200) begin
      start = (sent == restart_at);
      if (toggle && (cyc % 2 == 1)) begin
        bus.in_valid = 1'b0;
        stalls++;
      end else begin
        bus.in_valid = 1'b1;
        bus.in_pixel = cur_px[sent];
        if (bus.in_ready) begin
          e.x = XW'(x); e.y = YW'(y); e.v = cur_ev[sent];
          sb.push_back(e);
          sent++;
          x++;
          if (x == IMG_W) begin x = 0; y++; end
        end
      end
      @(posedge clock); #1;
      cyc++;
    end
    start = 1'b0;
    bus.in_valid = 1'b0;
    check("frame_accepted_all", sent, NPIX);
    check("done_low_with_last_strobe", done, 0);
    check("busy_with_last_strobe", busy, 1);
    @(posedge clock); #1;
    check("done_pulse", done, 1);
    check("busy_drops_with_done", busy, 0);
    check("cycle_count_at_done", cycle_count, exp_cc(sent + stalls + 1));
    check("strobe_count", strobes - s0, NPIX);
    check("scoreboard_drained", sb.size(), 0);
    @(posedge clock); #1;
    check("done_one_cycle", done, 0);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_pixel = '0;

    set_frame(0, 8'd0,   1'b0, {8'd10, 8'd20, 8'd30, 8'd40, 8'd40, 8'd30, 8'd20, 8'd10}, 8'b0111_0000);
    set_frame(1, 8'd0,   1'b0, {8{8'd100}},                                             8'b0000_0000);
    set_frame(2, 8'd1,   1'b0, {8{8'd100}},                                             8'b1111_1111);
    set_frame(3, 8'd1,   1'b1, {8{8'd100}},                                             8'b0000_0000);
    set_frame(4, 8'd1,   1'b0, {{4{8'd200}}, {4{8'd0}}},                                8'b1111_1111);
    set_frame(5, 8'd255, 1'b0, {8{8'd255}},                                             8'b1111_1111);
    set_frame(6, 8'd0,   1'b1, {8'd10, 8'd20, 8'd30, 8'd40, 8'd40, 8'd30, 8'd20, 8'd10}, 8'b1000_1111);

    #12;
    check("reset_in_ready", bus.in_ready, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_ovalid", bus.oValid, 0);
    check("reset_ovalue", bus.oValue, 0);
    check("reset_ox_oy", {bus.oX, bus.oY}, 0);
    check("reset_cycle_count", cycle_count, 0);
    @(negedge clock) not_reset = 1'b1;
    @(posedge clock); #1;

    for (int f = 0; f < NFRM; f++) begin
      load_frame(f);
      run_frame(tbl[f*NPIX].c, tbl[f*NPIX].inv, 1'b0, -1);
    end

    // Stalled random frame checked against the reference model.
    begin
      logic [7:0] c;
      logic       inv;
      c   = 8'($urandom_range(0, 40));
      inv = 1'($urandom_range(0, 1));
      for (int k = 0; k < NPIX; k++) cur_px[k] = 8'($urandom_range(0, 255));
      for (int k = 0; k < NPIX; k++) cur_ev[k] = model_v(k, c, inv);
      run_frame(c, inv, 1'b1, -1);
    end

    // start mid-RUN must not relatch offset or restart coordinates.
    load_frame(2);
    run_frame(8'd1, 1'b0, 1'b0, 3);

    // Reset mid-frame discards the partial frame.
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_t e;
      bus.in_valid = 1'b1;
      bus.in_pixel = 8'd50;
      e.x = XW'(i); e.y = '0; e.v = 1'b0;
      sb.push_back(e);
      @(posedge clock); #1;
    end
    bus.in_valid = 1'b0;
    check("pre_reset_ovalid", bus.oValid, 1);
    check("pre_reset_ox", bus.oX, 2);
    #1 not_reset = 1'b0;
    #1;
    check("async_reset_ovalid", bus.oValid, 0);
    check("async_reset_ox_oy", {bus.oX, bus.oY}, 0);
    check("async_reset_busy", busy, 0);
    check("async_reset_in_ready", bus.in_ready, 0);
    check("async_reset_cycle_count", cycle_count, 0);
    sb.delete();
    @(negedge clock) not_reset = 1'b1;
    @(posedge clock); #1;
    load_frame(0);
    run_frame(8'd0, 1'b0, 1'b0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
